// File: rtl/user_rom_streamer_pkg.sv
// Shared types for the user ROM string streamer: OBI config/struct defaults,
// FSM state encoding and word geometry.
package user_rom_streamer_pkg;

  typedef struct packed {
    logic [31:0] AddrWidth;
    logic [31:0] DataWidth;
    logic [31:0] IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: 32'd32,
    DataWidth: 32'd32,
    IdWidth:   32'd1
  };

  localparam int unsigned ObiAddrW = 32;
  localparam int unsigned ObiDataW = 32;
  localparam int unsigned ObiIdW   = 1;

  typedef struct packed {
    logic [ObiAddrW-1:0]   addr;
    logic                  we;
    logic [ObiDataW/8-1:0] be;
    logic [ObiDataW-1:0]   wdata;
    logic [ObiIdW-1:0]     aid;
    logic                  a_optional;
  } obi_default_a_chan_t;

  typedef struct packed {
    logic                req;
    obi_default_a_chan_t a;
  } obi_default_req_t;

  typedef struct packed {
    logic [ObiDataW-1:0] rdata;
    logic [ObiIdW-1:0]   rid;
    logic                err;
    logic                r_optional;
  } obi_default_r_chan_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    obi_default_r_chan_t r;
  } obi_default_rsp_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } user_rom_streamer_state_e;

  // The byte selector and the address stride both assume 4 chars per word.
  localparam int unsigned BytesPerWord = ObiDefaultConfig.DataWidth / 8;

endpackage

// File: rtl/user_rom_streamer_unpack.sv
// Word buffer with a little-endian byte selector; byte 0 is presented first
// after a load and advance_i steps to the next byte, wrapping 3 -> 0.
module user_rom_streamer_unpack
  import user_rom_streamer_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_i,
  input  logic [8*BytesPerWord-1:0] word_i,
  input  logic                      advance_i,
  output logic [7:0]                byte_o,
  output logic                      last_o
);

  logic [8*BytesPerWord-1:0] word_q;
  logic [1:0]                byte_idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q     <= '0;
      byte_idx_q <= '0;
    end else if (load_i) begin
      word_q     <= word_i;
      byte_idx_q <= '0;
    end else if (advance_i) begin
      byte_idx_q <= byte_idx_q + 2'd1;
    end
  end

  assign byte_o = word_q[{byte_idx_q, 3'b000} +: 8];
  assign last_o = (byte_idx_q == 2'd3);

endmodule

// File: rtl/user_rom_streamer.sv
// OBI manager that fetches a NUL-terminated string one word at a time (one read
// outstanding) and streams its chars out on a valid/ready port held until accepted.
module user_rom_streamer
  import user_rom_streamer_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
  parameter type         obi_req_t = obi_default_req_t,
  parameter type         obi_rsp_t = obi_default_rsp_t,
  parameter int unsigned MaxWords  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [ObiCfg.AddrWidth-1:0] base_addr_i,
  output obi_req_t                    obi_req_o,
  input  obi_rsp_t                    obi_rsp_i,
  output logic [7:0]                  char_o,
  output logic                        char_valid_o,
  input  logic                        char_ready_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int unsigned AddrWidth = ObiCfg.AddrWidth;
  localparam int unsigned WordIdxW  = $clog2(MaxWords + 1);

  user_rom_streamer_state_e state_q, state_d;
  logic [WordIdxW-1:0]      word_idx_q, word_idx_d;
  logic [AddrWidth-1:0]     base_q, base_d;
  logic                     err_q, err_d;

  logic       load;
  logic       advance;
  logic       last;
  logic [7:0] cur_byte;

  // rid is deliberately not checked: only one read is ever outstanding.
  logic unused_rsp;
  assign unused_rsp = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

  user_rom_streamer_unpack u_unpack (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (load),
    .word_i    (obi_rsp_i.r.rdata),
    .advance_i (advance),
    .byte_o    (cur_byte),
    .last_o    (last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      base_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      base_q     <= base_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    base_d       = base_q;
    err_d        = err_q;
    load         = 1'b0;
    advance      = 1'b0;
    obi_req_o    = '0;
    char_o       = '0;
    char_valid_o = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d     = base_addr_i;
          word_idx_d = '0;
          err_d      = 1'b0;
          state_d    = REQ;
        end
      end

      REQ: begin
        // Request fields depend only on registered state, so they hold until gnt.
        obi_req_o.req    = 1'b1;
        obi_req_o.a.addr = base_q + (AddrWidth'(word_idx_q) << 2);
        obi_req_o.a.be   = '1;
        if (obi_rsp_i.gnt) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            load    = 1'b1;
            state_d = EMIT;
          end
        end
      end

      EMIT: begin
        if (cur_byte == 8'h00) begin
          state_d = DONE;
        end else begin
          char_valid_o = 1'b1;
          char_o       = cur_byte;
          if (char_ready_i) begin
            advance = 1'b1;
            if (last) begin
              word_idx_d = word_idx_q + WordIdxW'(1);
              state_d    = (word_idx_d == WordIdxW'(MaxWords)) ? DONE : REQ;
            end
          end
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE) && (state_q != DONE);
  assign err_o  = err_q;

endmodule

// File: tb/tb_user_rom_streamer.sv
// Bench for user_rom_streamer: behavioural ROM subordinate with configurable
// grant delay / latency / error injection, char sink and string-level model.
module tb_user_rom_streamer;
  import user_rom_streamer_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             char_ready;
  logic [31:0]      base_addr;
  obi_default_req_t req;
  obi_default_rsp_t rsp;
  logic [7:0]       char_o;
  logic             char_valid;
  logic             busy;
  logic             done;
  logic             err;

  user_rom_streamer #(
    .ObiCfg    (ObiDefaultConfig),
    .obi_req_t (obi_default_req_t),
    .obi_rsp_t (obi_default_rsp_t),
    .MaxWords  (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .obi_req_o    (req),
    .obi_rsp_i    (rsp),
    .char_o       (char_o),
    .char_valid_o (char_valid),
    .char_ready_i (char_ready),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ROM contents and subordinate configuration (written by the test sequence)
  logic [31:0] rom [16];
  logic [31:0] cur_base = 0;
  int lat = 1, gdly = 0, err_read = -1, rdy_mode = 0;

  // Observations (written only by the responder / monitor processes)
  logic [31:0] reads [$];
  logic [7:0]  got [$];
  int stall_viol = 0, field_viol = 0, vld_viol = 0, done_cnt = 0;

  // Reference results and per-transfer snapshots
  logic [7:0]  exp_c [$];
  logic [31:0] exp_a [$];
  logic        exp_err;
  int s_r, s_g, s_d, s_v, s_s, s_f;
  logic s_err_start, s_busy_start;
  bit s_tmo;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ROM subordinate: grant after gdly stalled cycles, answer lat cycles later.
  initial begin : responder
    int pend, wcnt;
    logic [31:0] paddr;
    logic perr, stall;
    logic [3:0] idx;
    obi_default_req_t preq;
    pend = 0; wcnt = 0; stall = 0; perr = 0; paddr = 0; preq = '0;
    rsp = '0;
    forever begin
      @(posedge clk);
      #1;
      rsp = '0;
      if (stall && rst_n && (!req.req || req.a !== preq.a)) stall_viol++;
      stall = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          idx = 4'((paddr - cur_base) >> 2);
          rsp.rvalid  = 1'b1;
          rsp.r.err   = perr;
          rsp.r.rdata = perr ? 32'hDEAD_BEEF : rom[idx];
          rsp.r.rid   = 1'b1;
        end
      end
      if (req.req) begin
        if (req.a.we !== 1'b0 || req.a.be !== 4'hF || req.a.wdata !== 32'h0 ||
            req.a.aid !== 1'b0 || req.a.a_optional !== 1'b0) field_viol++;
        if (wcnt >= gdly) begin
          rsp.gnt = 1'b1;
          wcnt    = 0;
          pend    = lat;
          paddr   = req.a.addr;
          perr    = (reads.size() == err_read);
          reads.push_back(req.a.addr);
        end else begin
          wcnt++;
          stall = 1;
          preq  = req;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin : ready_drv
    int cyc;
    cyc = 0;
    char_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rdy_mode)
        0:       char_ready = 1'b1;
        1:       char_ready = (cyc % 3 == 0);
        default: char_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    logic pv, pr;
    logic [7:0] pc;
    pv = 0; pr = 0; pc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0;
        pr = 0;
      end else begin
        if (pv && !pr && (!char_valid || char_o !== pc)) vld_viol++;
        if (char_valid && char_ready) got.push_back(char_o);
        if (done) done_cnt++;
        pv = char_valid;
        pr = char_ready;
        pc = char_o;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish within 90000 cycles");
    $fatal(1);
  end

  // String-level model: walk words and bytes until NUL, error or 8 words.
  task automatic build_model(input int err_at);
    logic [7:0] c;
    exp_c.delete();
    exp_a.delete();
    exp_err = 1'b0;
    for (int w = 0; w < 8; w++) begin
      exp_a.push_back(cur_base + 32'(4 * w));
      if (w == err_at) begin
        exp_err = 1'b1;
        return;
      end
      for (int b = 0; b < 4; b++) begin
        c = rom[w][8*b +: 8];
        if (c == 8'h00) return;
        exp_c.push_back(c);
      end
    end
  endtask

  // len chars of random non-zero data followed by NUL (none if len >= 32).
  task automatic fill_rom(input int len);
    logic [7:0] c;
    for (int i = 0; i < 64; i++) begin
      c = (i < len || i >= 32) ? 8'($urandom_range(1, 255)) : 8'h00;
      rom[i/4][8*(i%4) +: 8] = c;
    end
  endtask

  task automatic load_ak_string();
    rom[0] = 32'h4326_4B41;  // "A K & C"
    rom[1] = 32'h2073_274B;  // "K ' s  "
    rom[2] = 32'h4349_5341;  // "A S I C"
    rom[3] = 32'h5A5A_5A00;  // NUL then junk
    for (int i = 4; i < 16; i++) rom[i] = 32'h5A5A_5A5A;
  endtask

  task automatic run_xfer(input logic [31:0] base, input int err_at, input int restart_at);
    s_r = reads.size(); s_g = got.size(); s_d = done_cnt;
    s_v = vld_viol; s_s = stall_viol; s_f = field_viol;
    cur_base = base;
    err_read = (err_at < 0) ? -1 : s_r + err_at;
    build_model(err_at);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = 32'h0BAD_0000;
    s_err_start  = err;
    s_busy_start = busy;
    s_tmo = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == restart_at) begin
        base_addr = $urandom;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done_cnt > s_d && !busy) begin
        s_tmo = 1'b0;
        break;
      end
    end
    tick();
    err_read = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = 32'h0;
    repeat (3) tick();
    checks++; if (req !== '0)        begin errors++; $display("FAIL reset_req: got %h, expected 0", req); end
    checks++; if (char_valid !== 0)  begin errors++; $display("FAIL reset_char_valid: got %b, expected 0", char_valid); end
    checks++; if (char_o !== 8'h00)  begin errors++; $display("FAIL reset_char: got %h, expected 00", char_o); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_busy_done_err: got %b, expected 000", {busy, done, err}); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if ({req.req, busy, done} !== 3'b000) begin errors++; $display("FAIL idle_after_reset: req/busy/done got %b, expected 000", {req.req, busy, done}); end
  endtask

  task automatic test_strings();
    // lat, gdly, ready mode; then random strings and bases
    int cfg [4][3] = '{'{1, 0, 0}, '{2, 3, 0}, '{1, 0, 1}, '{2, 1, 1}};
    logic [31:0] base;
    for (int it = 0; it < 10; it++) begin
      if (it < 4) begin
        load_ak_string();
        lat = cfg[it][0]; gdly = cfg[it][1]; rdy_mode = cfg[it][2];
        base = 32'h0;
      end else begin
        fill_rom($urandom_range(0, 31));
        lat = $urandom_range(1, 2); gdly = $urandom_range(0, 3); rdy_mode = $urandom_range(0, 1);
        base = $urandom;
        base[1:0] = 2'b00;
      end
      run_xfer(base, -1, -1);
      checks++; if (s_tmo) begin errors++; $display("FAIL strings[%0d] timeout: done_o not seen in 3000 cycles", it); end
      checks++;
      if (got.size() - s_g != exp_c.size()) begin
        errors++; $display("FAIL strings[%0d] char_count: got %0d, expected %0d", it, got.size() - s_g, exp_c.size());
      end else foreach (exp_c[k]) begin
        checks++; if (got[s_g+k] !== exp_c[k]) begin errors++; $display("FAIL strings[%0d] char%0d: got %h, expected %h", it, k, got[s_g+k], exp_c[k]); end
      end
      checks++;
      if (reads.size() - s_r != exp_a.size()) begin
        errors++; $display("FAIL strings[%0d] read_count: got %0d, expected %0d", it, reads.size() - s_r, exp_a.size());
      end else foreach (exp_a[k]) begin
        checks++; if (reads[s_r+k] !== exp_a[k]) begin errors++; $display("FAIL strings[%0d] addr%0d: got %h, expected %h", it, k, reads[s_r+k], exp_a[k]); end
      end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL strings[%0d] err: got %b, expected 0", it, err); end
      checks++; if (done_cnt - s_d != 1) begin errors++; $display("FAIL strings[%0d] done_pulse_cycles: got %0d, expected 1", it, done_cnt - s_d); end
      checks++; if (vld_viol != s_v || stall_viol != s_s || field_viol != s_f) begin
        errors++; $display("FAIL strings[%0d] stability: char/req/field violations got %0d/%0d/%0d, expected 0/0/0", it, vld_viol - s_v, stall_viol - s_s, field_viol - s_f);
      end
    end
  endtask

  task automatic test_full_length();
    fill_rom(32);
    lat = 1; gdly = $urandom_range(0, 2); rdy_mode = 0;
    run_xfer(32'h0, -1, -1);
    checks++; if (s_tmo) begin errors++; $display("FAIL full timeout: done_o not seen in 3000 cycles"); end
    checks++;
    if (got.size() - s_g != 32) begin
      errors++; $display("FAIL full char_count: got %0d, expected 32", got.size() - s_g);
    end else foreach (exp_c[k]) begin
      checks++; if (got[s_g+k] !== exp_c[k]) begin errors++; $display("FAIL full char%0d: got %h, expected %h", k, got[s_g+k], exp_c[k]); end
    end
    checks++; if (reads.size() - s_r != 8) begin errors++; $display("FAIL full read_count: got %0d, expected 8", reads.size() - s_r); end
    checks++; if (reads[reads.size()-1] !== 32'h1C) begin errors++; $display("FAIL full last_addr: got %h, expected 0000001c", reads[reads.size()-1]); end
    checks++; if (done_cnt - s_d != 1) begin errors++; $display("FAIL full done_pulse_cycles: got %0d, expected 1", done_cnt - s_d); end
  endtask

  task automatic test_error();
    fill_rom(20);
    lat = 2; gdly = 1; rdy_mode = 0;
    run_xfer(32'h100, 1, -1);
    checks++; if (s_tmo) begin errors++; $display("FAIL error timeout: done_o not seen in 3000 cycles"); end
    checks++;
    if (got.size() - s_g != 4) begin
      errors++; $display("FAIL error char_count: got %0d, expected 4", got.size() - s_g);
    end else foreach (exp_c[k]) begin
      checks++; if (got[s_g+k] !== exp_c[k]) begin errors++; $display("FAIL error char%0d: got %h, expected %h", k, got[s_g+k], exp_c[k]); end
    end
    checks++; if (reads.size() - s_r != 2) begin errors++; $display("FAIL error read_count: got %0d, expected 2", reads.size() - s_r); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL error err_sticky: got %b, expected 1", err); end
    checks++; if (done_cnt - s_d != 1) begin errors++; $display("FAIL error done_pulse_cycles: got %0d, expected 1", done_cnt - s_d); end
    repeat (3) tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL error err_held_idle: got %b, expected 1", err); end
    fill_rom(6);
    run_xfer(32'h200, -1, -1);
    checks++; if (s_err_start !== 1'b0 || s_busy_start !== 1'b1) begin
      errors++; $display("FAIL error clear_on_start: err/busy got %b/%b, expected 0/1", s_err_start, s_busy_start);
    end
    checks++; if (got.size() - s_g != 6 || err !== 1'b0) begin
      errors++; $display("FAIL error recovery: chars %0d err %b, expected 6 and 0", got.size() - s_g, err);
    end
  endtask

  task automatic test_reset_midway();
    int r0, g0, d0;
    bit seen;
    // A stray start while busy must not restart or rebase the transfer.
    load_ak_string();
    lat = 1; gdly = 0; rdy_mode = 1;
    run_xfer(32'h40, -1, 6);
    checks++;
    if (s_tmo || got.size() - s_g != exp_c.size() || reads.size() - s_r != exp_a.size()) begin
      errors++; $display("FAIL busy_start: chars %0d reads %0d tmo %0b, expected %0d %0d 0", got.size() - s_g, reads.size() - s_r, s_tmo, exp_c.size(), exp_a.size());
    end else foreach (exp_c[k]) begin
      checks++; if (got[s_g+k] !== exp_c[k]) begin errors++; $display("FAIL busy_start char%0d: got %h, expected %h", k, got[s_g+k], exp_c[k]); end
    end
    checks++; if (reads[reads.size()-1] !== 32'h4C) begin errors++; $display("FAIL busy_start last_addr: got %h, expected 0000004c", reads[reads.size()-1]); end

    // Reset while a char is stalled in EMIT.
    rdy_mode = 2; cur_base = 32'h0; d0 = done_cnt;
    base_addr = 32'h0; start = 1'b1; tick(); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin tick(); seen = char_valid; end
    checks++; if (!seen) begin errors++; $display("FAIL emit_reached: char_valid got 0 within 200 cycles, expected 1"); end
    rst_n = 1'b0;
    #1;
    checks++; if ({req !== '0, char_valid, char_o != 8'h00, busy, done, err} !== 6'b0) begin
      errors++; $display("FAIL reset_in_emit: req %h valid %b char %h busy %b done %b err %b, expected all 0", req, char_valid, char_o, busy, done, err);
    end
    tick(); rst_n = 1'b1; tick();
    checks++; if (busy !== 1'b0 || char_valid !== 1'b0 || done_cnt != d0) begin
      errors++; $display("FAIL after_emit_reset: busy %b valid %b done pulses %0d, expected 0 0 0", busy, char_valid, done_cnt - d0);
    end

    // Reset in WAIT; the late (erroring) response must be ignored.
    rdy_mode = 0; lat = 5; r0 = reads.size(); g0 = got.size(); d0 = done_cnt;
    err_read = r0;
    start = 1'b1; tick(); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin tick(); seen = (reads.size() > r0); end
    checks++; if (!seen) begin errors++; $display("FAIL wait_reached: no grant within 50 cycles"); end
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (10) tick();
    err_read = -1;
    checks++; if ({busy, char_valid, err} !== 3'b000 || got.size() != g0 || done_cnt != d0) begin
      errors++; $display("FAIL stray_rvalid: busy %b valid %b err %b chars %0d done %0d, expected 0 0 0 0 0", busy, char_valid, err, got.size() - g0, done_cnt - d0);
    end
    lat = 1;
    run_xfer(32'h80, -1, -1);
    checks++; if (s_tmo || got.size() - s_g != 12 || reads.size() - s_r != 4) begin
      errors++; $display("FAIL post_reset_xfer: chars %0d reads %0d tmo %0b, expected 12 4 0", got.size() - s_g, reads.size() - s_r, s_tmo);
    end
  endtask

  initial begin : main
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 32'h0;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    test_reset();
    test_strings();
    test_full_length();
    test_error();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
